// File: rtl/instruction_encoder.sv
// RV32I instruction word assembler: two-stage valid/ready pipeline (check, pack) with word-address counter.
// Define INSTR_ENCODER_CHECK_EN to enable immediate range and alignment checks.
module instruction_encoder #(
  parameter int unsigned             DATA_WIDTH = 32,
  parameter int unsigned             ADDR_WIDTH = 10,
  parameter logic [ADDR_WIDTH-1:0]   BASE_ADDR  = '0
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  flush_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [2:0]            fmt_i,
  input  logic [6:0]            opcode_i,
  input  logic [4:0]            rd_i,
  input  logic [4:0]            rs1_i,
  input  logic [4:0]            rs2_i,
  input  logic [2:0]            funct3_i,
  input  logic [6:0]            funct7_i,
  input  logic [DATA_WIDTH-1:0] imm_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [DATA_WIDTH-1:0] instr_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  err_o,
  output logic [1:0]            err_code_o
);

  typedef enum logic [2:0] {
    FMT_R = 3'd0, FMT_I = 3'd1, FMT_S = 3'd2, FMT_B = 3'd3, FMT_U = 3'd4, FMT_J = 3'd5
  } fmt_e;

  typedef enum logic [1:0] {
    ERR_NONE = 2'd0, ERR_RANGE = 2'd1, ERR_MISALIGN = 2'd2, ERR_FMT = 2'd3
  } err_e;

  localparam logic [DATA_WIDTH-1:0] NOP = DATA_WIDTH'(32'h0000_0013);

  logic                  r_s1_valid;
  logic [2:0]            r_s1_fmt;
  logic [6:0]            r_s1_op;
  logic [4:0]            r_s1_rd;
  logic [4:0]            r_s1_rs1;
  logic [4:0]            r_s1_rs2;
  logic [2:0]            r_s1_f3;
  logic [6:0]            r_s1_f7;
  logic [DATA_WIDTH-1:0] r_s1_imm;
  err_e                  r_s1_err;

  logic                  r_s2_valid;
  logic [DATA_WIDTH-1:0] r_instr;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_err;
  logic [1:0]            r_err_code;

  err_e                  w_err;
  logic [DATA_WIDTH-1:0] w_pack;
  logic                  w_accept;
  logic                  w_s2_load;
  logic                  w_out_fire;

  assign in_ready_o  = !rst_i && !flush_i && !(r_s1_valid && r_s2_valid && !out_ready_i);
  assign w_accept    = in_valid_i && in_ready_o;
  assign w_s2_load   = !r_s2_valid || out_ready_i;
  assign out_valid_o = r_s2_valid && !rst_i;
  assign w_out_fire  = out_valid_o && out_ready_i;

  assign instr_o    = r_instr;
  assign addr_o     = r_addr;
  assign err_o      = r_err;
  assign err_code_o = r_err_code;

`ifdef INSTR_ENCODER_CHECK_EN
  logic w_ok11, w_ok12, w_ok20;
  assign w_ok11 = (&imm_i[DATA_WIDTH-1:11]) || !(|imm_i[DATA_WIDTH-1:11]);
  assign w_ok12 = (&imm_i[DATA_WIDTH-1:12]) || !(|imm_i[DATA_WIDTH-1:12]);
  assign w_ok20 = (&imm_i[DATA_WIDTH-1:20]) || !(|imm_i[DATA_WIDTH-1:20]);
`endif

  // Later assignments override earlier ones: illegal format > misaligned > range.
  always_comb begin
    w_err = ERR_NONE;
`ifdef INSTR_ENCODER_CHECK_EN
    case (fmt_i)
      FMT_I, FMT_S: if (!w_ok11) w_err = ERR_RANGE;
      FMT_B:        if (!w_ok12) w_err = ERR_RANGE;
      FMT_J:        if (!w_ok20) w_err = ERR_RANGE;
      FMT_U:        if (imm_i[11:0] != '0) w_err = ERR_RANGE;
      default:      ;
    endcase
    if ((fmt_i == FMT_B || fmt_i == FMT_J) && imm_i[0]) w_err = ERR_MISALIGN;
`endif
    if (fmt_i > FMT_J) w_err = ERR_FMT;
  end

  always_comb begin
    w_pack = NOP;
    case (r_s1_fmt)
      FMT_R: w_pack = {r_s1_f7, r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op};
      FMT_I: w_pack = {r_s1_imm[11:0], r_s1_rs1, r_s1_f3, r_s1_rd, r_s1_op};
      FMT_S: w_pack = {r_s1_imm[11:5], r_s1_rs2, r_s1_rs1, r_s1_f3, r_s1_imm[4:0], r_s1_op};
      FMT_B: w_pack = {r_s1_imm[12], r_s1_imm[10:5], r_s1_rs2, r_s1_rs1, r_s1_f3,
                       r_s1_imm[4:1], r_s1_imm[11], r_s1_op};
      FMT_U: w_pack = {r_s1_imm[DATA_WIDTH-1:12], r_s1_rd, r_s1_op};
      FMT_J: w_pack = {r_s1_imm[20], r_s1_imm[10:1], r_s1_imm[11], r_s1_imm[19:12],
                       r_s1_rd, r_s1_op};
      default: w_pack = NOP;
    endcase
  end

  // S1 payload needs no reset: it is qualified by r_s1_valid.
  always_ff @(posedge clk_i) begin
    if (w_accept) begin
      r_s1_fmt <= fmt_i;
      r_s1_op  <= opcode_i;
      r_s1_rd  <= rd_i;
      r_s1_rs1 <= rs1_i;
      r_s1_rs2 <= rs2_i;
      r_s1_f3  <= funct3_i;
      r_s1_f7  <= funct7_i;
      r_s1_imm <= imm_i;
      r_s1_err <= w_err;
    end
  end

  // A handshake in the flush cycle completes, yet the counter still ends at BASE_ADDR.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_s1_valid <= 1'b0;
      r_s2_valid <= 1'b0;
      r_instr    <= '0;
      r_addr     <= BASE_ADDR;
      r_err      <= 1'b0;
      r_err_code <= '0;
    end else begin
      if (w_out_fire) r_addr <= r_addr + ADDR_WIDTH'(1);
      if (flush_i) begin
        r_s1_valid <= 1'b0;
        r_s2_valid <= 1'b0;
        r_addr     <= BASE_ADDR;
      end else begin
        if (w_s2_load) begin
          r_s2_valid <= r_s1_valid;
          if (r_s1_valid) begin
            r_instr    <= (r_s1_err != ERR_NONE) ? NOP : w_pack;
            r_err      <= (r_s1_err != ERR_NONE);
            r_err_code <= r_s1_err;
          end
        end
        if (w_accept)       r_s1_valid <= 1'b1;
        else if (w_s2_load) r_s1_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_instruction_encoder.sv
// Directed self-checking bench for instruction_encoder: default instance plus a 2-bit address instance for wrap.
module tb_instruction_encoder;

`ifdef INSTR_ENCODER_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, flush, in_valid, out_ready;
  logic [2:0]  fmt;
  logic [6:0]  opcode, funct7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  funct3;
  logic [31:0] imm;

  logic        in_ready, out_valid, err;
  logic [31:0] instr;
  logic [9:0]  addr;
  logic [1:0]  err_code;

  logic        w_in_ready, w_out_valid, w_err;
  logic [31:0] w_instr;
  logic [1:0]  w_addr, w_err_code;

  instruction_encoder u_dut (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(in_ready),
    .fmt_i(fmt), .opcode_i(opcode), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .funct3_i(funct3),
    .funct7_i(funct7), .imm_i(imm), .out_valid_o(out_valid), .out_ready_i(out_ready),
    .instr_o(instr), .addr_o(addr), .err_o(err), .err_code_o(err_code)
  );

  instruction_encoder #(.ADDR_WIDTH(2)) u_wrap (
    .clk_i(clk), .rst_i(rst), .flush_i(flush), .in_valid_i(in_valid), .in_ready_o(w_in_ready),
    .fmt_i(fmt), .opcode_i(opcode), .rd_i(rd), .rs1_i(rs1), .rs2_i(rs2), .funct3_i(funct3),
    .funct7_i(funct7), .imm_i(imm), .out_valid_o(w_out_valid), .out_ready_i(out_ready),
    .instr_o(w_instr), .addr_o(w_addr), .err_o(w_err), .err_code_o(w_err_code)
  );

  typedef struct {
    logic [31:0] instr;
    logic [1:0]  code;
  } exp_t;

  exp_t        q[$];
  int unsigned exp_addr = 0;
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Scoreboard: outputs are sampled on the falling edge; the handshake lands on the next rising edge.
  always @(negedge clk) begin
    if (out_valid && out_ready) begin
      exp_t e;
      check("word_expected", 32'(q.size() != 0), 32'd1);
      check("wrap_valid", 32'(w_out_valid), 32'd1);
      if (q.size() != 0) begin
        e = q.pop_front();
        check("instr", instr, e.instr);
        check("err", 32'(err), 32'(e.code != 2'd0));
        check("err_code", 32'(err_code), 32'(e.code));
        check("addr", 32'(addr), exp_addr);
        check("wrap_addr", 32'(w_addr), exp_addr % 4);
        check("wrap_instr", w_instr, e.instr);
        check("wrap_err", 32'({w_err, w_err_code}), 32'({e.code != 2'd0, e.code}));
      end
      exp_addr = (exp_addr + 1) % 1024;
    end
    if (rst || flush) begin
      q.delete();
      exp_addr = 0;
    end
  end

  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                       input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] im);
    fmt = f; opcode = op; rd = d; rs1 = s1; rs2 = s2; funct3 = f3; funct7 = f7; imm = im;
    in_valid = 1'b1;
  endtask

  task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] d,
                      input logic [4:0] s1, input logic [4:0] s2, input logic [2:0] f3,
                      input logic [6:0] f7, input logic [31:0] im,
                      input logic [31:0] e_instr, input logic [1:0] e_code);
    int unsigned k = 0;
    drive(f, op, d, s1, s2, f3, f7, im);
    #1;
    while (!in_ready && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("accept", 32'(k < 20), 32'd1);
    if (k < 20) q.push_back('{instr: e_instr, code: e_code});
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int unsigned k = 0;
    while (q.size() != 0 && k < 30) begin
      @(posedge clk); #1;
      k++;
    end
    check("drain", 32'(q.size()), 32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_instr"}, instr, 32'd0);
    check({tag, "_addr"}, 32'(addr), 32'd0);
    check({tag, "_err"}, 32'({err, err_code}), 32'd0);
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    drive(3'd0, 7'd0, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check_reset_outputs("rst");
    rst = 1'b0;
    @(posedge clk); #1;

    // Latency: accepted in cycle c, visible in c+2.
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 32'h0050_0093, 2'd0);
    check("lat_c1_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    check("lat_c2_valid", 32'(out_valid), 32'd1);
    check("lat_c2_instr", instr, 32'h0050_0093);
    check("lat_c2_addr", 32'(addr), 32'd0);

    // Back-to-back stream across every format and the error classes.
    send(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0,          32'h4031_00B3, 2'd0);
    send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8,           32'h0020_A423, 2'd0);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFF8,   32'hFE20_8CE3, 2'd0);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000,   32'h1234_52B7, 2'd0);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16,          32'h0100_00EF, 2'd0);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_F800,   32'h8000_0093, 2'd0);
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048,
         CHK ? 32'h0000_0013 : 32'h8000_0093, CHK ? 2'd1 : 2'd0);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3,
         CHK ? 32'h0000_0013 : 32'h0020_00EF, CHK ? 2'd2 : 2'd0);
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'h0010_0001,
         CHK ? 32'h0000_0013 : 32'h8000_00EF, CHK ? 2'd2 : 2'd0);
    send(3'd6, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0,           32'h0000_0013, 2'd3);
    drain();

    // Backpressure: two bundles held, third refused until release.
    out_ready = 1'b0;
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,         32'h0050_0093, 2'd0);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 2'd0);
    drive(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0);
    for (int i = 0; i < 5; i++) begin
      #1;
      check("bp_in_ready", 32'({in_ready, w_in_ready}), 32'd0);
      check("bp_hold_valid", 32'(out_valid), 32'd1);
      check("bp_hold_instr", instr, 32'h0050_0093);
      @(posedge clk);
    end
    #1;
    out_ready = 1'b1;
    send(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0,        32'h4031_00B3, 2'd0);
    drain();

    // Flush with two words in flight; input offered during flush is dropped.
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,         32'h0050_0093, 2'd0);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 2'd0);
    flush = 1'b1;
    drive(3'd0, 7'h33, 5'd1, 5'd2, 5'd3, 3'd0, 7'h20, 32'd0);
    #1;
    check("flush_in_ready", 32'(in_ready), 32'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_addr", 32'(addr), 32'd0);
    send(3'd3, 7'h63, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'hFFFF_FFF8, 32'hFE20_8CE3, 2'd0);
    drain();

    // Reset mid-stream.
    send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5,         32'h0050_0093, 2'd0);
    send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000, 32'h1234_52B7, 2'd0);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready), 32'd0);
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    @(posedge clk); #1;
    rst = 1'b0;
    check_reset_outputs("mid_rst");
    send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16,        32'h0100_00EF, 2'd0);
    drain();

    repeat (2) @(posedge clk);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/instruction_encoder.md
# instruction_encoder

- Assembles 32-bit RV32I instruction words from decoded fields: format, opcode, register indices, funct3/funct7 and a full 32-bit immediate.
- Packs the immediate into the I/S/B/U/J bit layouts the decode stage unpacks, checks that it is representable, and streams each word out with a word address for instruction-memory preload.
- Two-stage valid/ready pipeline; throughput one word per cycle.

## Interface

- DATA_WIDTH, 32, instruction/immediate width (from `defines`)
- ADDR_WIDTH, 10, word-address width of `addr_o`
- BASE_ADDR, 0, first word address after reset/flush
---
- clk_i  input  1  clock; all logic on rising edge
- rst_i  input  1  synchronous, active-high reset
- flush_i  input  1  synchronous pipeline flush and address rewind
- in_valid_i  input  1  field bundle valid
- in_ready_o  output  1  bundle accepted when `in_valid_i && in_ready_o`
- fmt_i  input  3  0=R, 1=I, 2=S, 3=B, 4=U, 5=J; 6,7 illegal
- opcode_i  input  7  bits [6:0]
- rd_i, rs1_i, rs2_i  input  5 each  register indices
- funct3_i  input  3  funct3
- funct7_i  input  7  funct7 (R only)
- imm_i  input  DATA_WIDTH  signed byte-offset or value immediate
- out_valid_o  output  1  word valid
- out_ready_i  input  1  consumer ready
- instr_o  output  DATA_WIDTH  encoded instruction
- addr_o  output  ADDR_WIDTH  word address of `instr_o`
- err_o  output  1  word replaced by NOP because of an error
- err_code_o  output  2  0=none, 1=range, 2=misaligned, 3=illegal format

## Operation

- **S1 (check):**
  - Registers the fields.
  - Computes the error code with priority illegal format > misaligned > range.
- **Range rules:**
  - I, S: `imm_i[31:11]` all equal.
  - B: `imm_i[31:12]` all equal.
  - J: `imm_i[31:20]` all equal.
  - U: `imm_i[11:0]` must be 0, otherwise range error.
  - R: imm ignored.
- **Misaligned:** B or J with `imm_i[0]=1`.
- **S2 (pack), registered output:**
  - R: funct7|rs2|rs1|funct3|rd|opcode.
  - I: imm[11:0]|rs1|funct3|rd|opcode.
  - S: imm[11:5]|rs2|rs1|funct3|imm[4:0]|opcode.
  - B: imm[12]|imm[10:5]|rs2|rs1|funct3|imm[4:1]|imm[11]|opcode.
  - U: imm[31:12]|rd|opcode.
  - J: imm[20]|imm[10:1]|imm[11]|imm[19:12]|rd|opcode.
- **Error handling:** on any error, `instr_o`=32'h0000_0013 (addi x0,x0,0), `err_o`=1, and `err_code_o` carries the code. The word still occupies an address slot.
- **Address counter:**
  - Increments on each output handshake.
  - Wraps from 2^ADDR_WIDTH−1 to 0.
  - `addr_o` is the address of the word currently presented.

## Timing

- **Latency:** a bundle accepted in cycle c appears on `out_valid_o` in cycle c+2 when there is no backpressure.
- **S2 loads** when `!s2_valid || out_ready_i`. S1 advances under the same condition.
- **`in_ready_o`** = `!rst_i && !flush_i && !(s1_valid && s2_valid && !out_ready_i)`. This is combinational.
- **Backpressure:** at most two bundles are held. No loss and no reordering. Output fields stay stable while `out_valid_o && !out_ready_i`.
- **Reset:**
  - `out_valid_o`=0, `in_ready_o`=0 while `rst_i` is high.
  - `instr_o`=0, `addr_o`=BASE_ADDR, `err_o`=0, `err_code_o`=0.
  - Both stage valids are cleared.
  - Reset mid-stream discards in-flight words.
- **Flush:**
  - Clears both stage valids at the next edge.
  - Sets `addr_o` to BASE_ADDR.
  - Input offered in the flush cycle is not accepted.
  - An output handshake in the flush cycle completes, but the counter still ends at BASE_ADDR.
  - `rst_i` dominates `flush_i`.
- **Simultaneous output handshake and new input:** a full pipeline shifts in the same cycle, keeping throughput at one word per cycle.

## Configuration

- **`INSTR_ENCODER_CHECK_EN` defined:** range and misalignment checks are active (codes 1, 2).
- **Not defined:**
  - Codes 1 and 2 are never produced.
  - Immediate bits are packed as-is with silent truncation.
  - `imm_i[0]` is dropped for B/J.
  - The illegal-format check (code 3, NOP substitution) remains in both builds.

## Test plan

- **I-type:** fmt=1, op=0x13, rd=1, rs1=0, f3=0, imm=5 → `instr_o`=0x00500093, `addr_o`=0, `err_o`=0, in cycle c+2.
- **B-type and U-type:**
  - fmt=3, op=0x63, rs1=1, rs2=2, f3=0, imm=0xFFFFFFF8 → 0xFE208CE3.
  - fmt=4, op=0x37, rd=5, imm=0x12345000 → 0x123452B7.
- **Errors (check enabled):**
  - I with imm=2048 → 0x00000013, err code 1.
  - J with imm=3 → err code 2.
  - fmt=6 → err code 3.
  - Each error word still consumes one address.
- **Backpressure:** stream 3 bundles with `out_ready_i`=0 for 5 cycles → `in_ready_o` drops after 2 are accepted; on release, words appear in order at addrs 0,1,2.
- **Wrap:** ADDR_WIDTH=2, 5 transfers → addrs 0,1,2,3,0.
- **Flush and reset:**
  - Flush with 2 words in flight → `out_valid_o`=0 next cycle; next word is at BASE_ADDR.
  - `rst_i` mid-stream gives the same result, with all outputs at reset values.
